axi_wr_arbiter: RTL

//  Shares one AXI write master port (AW + W channels) between NUM_REQ burst requesters.

---
 rtl/axi_wr_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - round-robin AXI write (AW+W) burst arbiter, one burst in flight
// Optional handshake timeout: define AXI_ARB_TIMEOUT_EN.
module axi_wr_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADRESS_WIDTH = 32,
   parameter int NUM_REQ      = 2,
   parameter int TIMEOUT_CYC  = 16
) (
   input  logic                             ACLK,
   input  logic                             ARESET,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*ADRESS_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*4-1:0]             req_len,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   input  logic [NUM_REQ-1:0]               req_wvalid,
   output logic [NUM_REQ-1:0]               req_wready,
   output logic [ADRESS_WIDTH-1:0]          AWADDR,
   output logic [3:0]                       AWLEN,
   output logic [2:0]                       AWSIZE,
   output logic [1:0]                       AWBURST,
   output logic                             AWVALID,
   input  logic                             AWREADY,
   output logic [DATA_WIDTH-1:0]            WDATA,
   output logic                             WLAST,
   output logic                             WVALID,
   input  logic                             WREADY,
   output logic [$clog2(NUM_REQ)-1:0]       grant_id,
   output logic                             busy,
   output logic                             timeout_err
);
   localparam int GW = $clog2(NUM_REQ);
   localparam logic [2:0] BEAT_SIZE = 3'($clog2(DATA_WIDTH / 8));

   typedef enum logic [1:0] {S_IDLE, S_AW, S_W} state_t;

   state_t        state, state_nxt;
   logic [GW-1:0] last_grant;
   logic [GW-1:0] pick, cand;
   logic          pick_vld;
   logic [3:0]    beat_cnt;
   logic          cur_wvalid;
   logic          aw_hs, w_hs, tmo;

   assign busy       = (state != S_IDLE);
   assign cur_wvalid = req_wvalid[grant_id];
   assign aw_hs      = (state == S_AW) && AWVALID && AWREADY;
   assign w_hs       = (state == S_W) && cur_wvalid && WREADY;

   // Scan downwards so the candidate nearest to last_grant+1 is written last and wins.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      cand     = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = GW'((int'(last_grant) + k) % NUM_REQ);
         if (req_valid[cand]) begin
            pick     = cand;
            pick_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      WVALID     = 1'b0;
      WDATA      = '0;
      WLAST      = 1'b0;
      req_wready = '0;
      case (state)
         S_IDLE: if (pick_vld) state_nxt = S_AW;
         S_AW: begin
            if (aw_hs)    state_nxt = S_W;
            else if (tmo) state_nxt = S_IDLE;
         end
         S_W: begin
            WVALID               = cur_wvalid;
            WDATA                = req_wdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
            WLAST                = (beat_cnt == AWLEN);
            req_wready[grant_id] = WREADY;
            if (w_hs && (beat_cnt == AWLEN)) state_nxt = S_IDLE;
            else if (tmo)                    state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         grant_id   <= '0;
         last_grant <= GW'(NUM_REQ - 1);
         AWADDR     <= '0;
         AWLEN      <= '0;
         AWSIZE     <= '0;
         AWBURST    <= '0;
         AWVALID    <= 1'b0;
         req_ready  <= '0;
         beat_cnt   <= '0;
      end else begin
         req_ready <= '0;
         case (state)
            S_IDLE: if (pick_vld) begin
               grant_id        <= pick;
               AWADDR          <= req_addr[pick*ADRESS_WIDTH +: ADRESS_WIDTH];
               AWLEN           <= req_len[pick*4 +: 4];
               AWSIZE          <= BEAT_SIZE;
               AWBURST         <= 2'b01;
               AWVALID         <= 1'b1;
               req_ready[pick] <= 1'b1;
            end
            S_AW: begin
               if (aw_hs) begin
                  AWVALID  <= 1'b0;
                  beat_cnt <= '0;
               end else if (tmo) begin
                  AWVALID    <= 1'b0;
                  last_grant <= grant_id;
               end
            end
            S_W: begin
               if (w_hs) begin
                  beat_cnt <= beat_cnt + 4'd1;
                  if (beat_cnt == AWLEN) last_grant <= grant_id;
               end else if (tmo) begin
                  last_grant <= grant_id;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef AXI_ARB_TIMEOUT_EN
   logic [7:0] wait_cnt;
   logic       stall;

   assign stall = ((state == S_AW) && !AWREADY) || ((state == S_W) && cur_wvalid && !WREADY);
   assign tmo   = stall && (wait_cnt == 8'(TIMEOUT_CYC - 1));

   // Held at zero in IDLE, so every entry to AW starts a fresh count.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= tmo;
         if ((state == S_IDLE) || aw_hs || w_hs) wait_cnt <= '0;
         else if (stall)                         wait_cnt <= wait_cnt + 8'd1;
      end
   end
`else
   assign tmo         = (TIMEOUT_CYC < 0);
   assign timeout_err = 1'b0;
`endif

endmodule
